fpmul_sched: RTL

Two-port scheduler that shares one fixed-latency FP multiply pipeline (FPMul plus its aux-flag stage) between two requesters. It accepts operand pairs over valid/ready, arbitrates round-robin, issues at most one multiply per cycle and tracks each in-flight operation with a tag shift register. It routes each returned product and its 4 exception flags (NAN, INF, ZERO, DNF) to the originating requester's result FIFO. A credit scheme guarantees every issued operation has a reserved FIFO slot, so the multiplier pipeline is never stalled.

---
 rtl/fpmul_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 44 ++++
 rtl/fpmul_sched.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fpmul_pkg.sv
// Shared types for the FP multiply scheduler: result FIFO entry layout,
// exception flag positions and the in-flight tag carried alongside the multiplier.
package fpmul_pkg;
  localparam int FLAG_W    = 4;
  localparam int RES_W     = 32;
  localparam int ENTRY_W   = FLAG_W + RES_W;
  localparam int FLAG_NAN  = 3;
  localparam int FLAG_INF  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_DNF  = 0;

  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic [RES_W-1:0]  result;
  } res_entry_t;

  typedef struct packed {
    logic v;
    logic id;
  } tag_t;
endpackage

// File: rtl/sync_fifo.sv
// Registered write-then-read FIFO: a pushed entry becomes visible at the head
// on the following cycle; there is no push-to-output bypass.
module sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fpmul_sched.sv
// Shares one fixed-latency FP multiplier between two requesters: credit-gated
// round-robin issue, tag shift register tracking in-flight ops, per-port result FIFOs.
module fpmul_sched
  import fpmul_pkg::*;
#(
  parameter int LAT   = 4,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  in_valid,
  output logic [1:0]  in_ready,
  input  logic [31:0] in_a0,
  input  logic [31:0] in_b0,
  input  logic [31:0] in_a1,
  input  logic [31:0] in_b1,
  output logic        mul_go,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_valid,
  input  logic [31:0] mul_res,
  input  logic [3:0]  mul_flags,
  output logic [1:0]  out_valid,
  input  logic [1:0]  out_ready,
  output logic [35:0] out_data0,
  output logic [35:0] out_data1,
  output logic        err
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0][CW-1:0] cred;
  logic               last;
  logic               issue_id;
  logic [1:0]         elig;
  logic [1:0]         grant;
  logic [1:0]         xfer;
  logic [1:0]         pop;
  logic [1:0]         push;
  logic [1:0]         empty;
  logic [1:0]         full;
  tag_t               tag_p [LAT];
  logic               tv;
  logic               tid;
  res_entry_t         wb_entry;
  res_entry_t         head0;
  res_entry_t         head1;

  // Arbitration: a port is eligible only while it holds a reserved FIFO slot.
  always_comb begin
    grant = 2'b00;
    for (int i = 0; i < 2; i++) elig[i] = in_valid[i] & (cred[i] != '0);
    if (elig == 2'b11) grant = last ? 2'b01 : 2'b10;
    else               grant = elig;
  end

  assign in_ready  = rst ? 2'b00 : grant;
  assign xfer      = in_valid & in_ready;
  assign out_valid = ~empty;
  assign pop       = ~empty & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) cred[i] <= CW'(DEPTH);
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (xfer[i] && !pop[i])      cred[i] <= cred[i] - CW'(1);
        else if (!xfer[i] && pop[i]) cred[i] <= cred[i] + CW'(1);
      end
    end
  end

  // Issue register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_go   <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
      issue_id <= 1'b0;
      last     <= 1'b1;
    end else begin
      mul_go <= |xfer;
      if (|xfer) begin
        mul_a    <= grant[1] ? in_a1 : in_a0;
        mul_b    <= grant[1] ? in_b1 : in_b0;
        issue_id <= grant[1];
        last     <= grant[1];
      end
    end
  end

  // Tag pipeline stages, aligned with the multiplier latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) tag_p[k] <= '0;
    end else begin
      tag_p[0] <= '{v: mul_go, id: issue_id};
      for (int k = 1; k < LAT; k++) tag_p[k] <= tag_p[k-1];
    end
  end

  assign tv       = tag_p[LAT-1].v;
  assign tid      = tag_p[LAT-1].id;
  assign wb_entry = '{flags: mul_flags, result: mul_res};

  // Writeback stage: a strobe that disagrees with the tag is dropped and flagged.
  assign push[0] = tv & mul_valid & ~tid;
  assign push[1] = tv & mul_valid & tid;

  always_ff @(posedge clk) begin
    if (rst)                    err <= 1'b0;
    else if (tv != mul_valid)   err <= 1'b1;
  end

  assert property (@(posedge clk) disable iff (rst) !(|(push & full)));

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst(rst), .push(push[0]), .din(wb_entry), .pop(pop[0]),
    .dout(head0), .empty(empty[0]), .full(full[0])
  );

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .push(push[1]), .din(wb_entry), .pop(pop[1]),
    .dout(head1), .empty(empty[1]), .full(full[1])
  );

  assign out_data0 = head0;
  assign out_data1 = head1;
endmodule
